alu_sequencer: RTL

Command-driven controller that sequences the ALU/register datapath, i.e. the A-D register file, add/sub, and/or, xor/not, shift/swap units and the flags register. It accepts one ALU command per handshake and produces the datapath's encoded control lines (outctl, loadctl, arg_l, arg_r, alt, calcfn, cin) cycle by cycle. Multi-step shifts reuse the shifter and feed the carry back through the flags register. It sits between the microcode/control unit and the ALU block.

---
 rtl/alu_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU command per handshake and drives the
// encoded datapath control lines (register file, ALU units, flags) one
// step per cycle. Multi-step shifts repeat the shifter step, and RCL
// takes its carry back from the flags register on every step.
module alu_sequencer #(
  parameter int unsigned CARRY_BIT = 1,
  parameter int unsigned MAX_SHIFT = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_dst,
  input  logic [1:0] cmd_src,
  input  logic [2:0] cmd_count,
  input  logic [3:0] flags_in,
  output logic [3:0] outctl,
  output logic [3:0] loadctl,
  output logic [1:0] arg_l,
  output logic [2:0] arg_r,
  output logic       alt,
  output logic       calcfn,
  output logic       cin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_RCL  = 4'h9;
  localparam logic [3:0] OP_SWAP = 4'hA;
  localparam logic [3:0] OP_MOV  = 4'hB;
  localparam logic [3:0] OP_CLR  = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;
  localparam logic [3:0] OP_INC  = 4'hE;

  state_t     state;
  state_t     next_state;
  logic [3:0] op_q;
  logic [1:0] dst_q;
  logic [1:0] src_q;
  logic [2:0] step_q;
  logic       err_q;
  logic       accept;
  logic       is_shift;
  logic       illegal;
  logic       carry;
  logic       unused_flags;

  // Only the carry bit of the flags feedback matters to sequencing.
  assign carry        = flags_in[CARRY_BIT];
  assign unused_flags = ^flags_in;

  assign accept   = cmd_valid && (state == IDLE);
  assign is_shift = (cmd_op == OP_SHL) || (cmd_op == OP_RCL);
  assign illegal  = (cmd_op == 4'hF) ||
                    (is_shift && (32'(cmd_count) > MAX_SHIFT));

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = (state == DONE) && err_q;

  // State register; reset abandons any in-flight command without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Command latch and step counter; the counter starts at steps-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 4'h0;
      dst_q  <= 2'd0;
      src_q  <= 2'd0;
      step_q <= 3'd0;
      err_q  <= 1'b0;
    end else if (accept) begin
      op_q  <= cmd_op;
      dst_q <= cmd_dst;
      src_q <= cmd_src;
      err_q <= illegal;
      if (is_shift && (cmd_count != 3'd0)) begin
        step_q <= cmd_count - 3'd1;
      end else begin
        step_q <= 3'd0;
      end
    end else if ((state == EXEC) && (step_q != 3'd0)) begin
      step_q <= step_q - 3'd1;
    end
  end

  // Next-state logic: legal commands execute, illegal ones go straight to DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = illegal ? DONE : EXEC;
        end
      end
      EXEC: begin
        if (step_q == 3'd0) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath control decode from the latched command; idle values outside EXEC.
  always_comb begin
    outctl  = 4'hF;
    loadctl = 4'hF;
    arg_l   = 2'd0;
    arg_r   = 3'd0;
    alt     = 1'b0;
    calcfn  = 1'b1;
    cin     = 1'b0;
    if (state == EXEC) begin
      arg_l   = dst_q;
      arg_r   = {1'b0, src_q};
      loadctl = {2'b00, dst_q};
      calcfn  = 1'b0;
      case (op_q)
        OP_ADD: outctl = 4'h5;
        OP_ADC: begin
          outctl = 4'h5;
          cin    = carry;
        end
        OP_SUB: begin
          outctl = 4'h5;
          alt    = 1'b1;
          cin    = 1'b1;
        end
        OP_SBC: begin
          outctl = 4'h5;
          alt    = 1'b1;
          cin    = carry;
        end
        OP_AND: outctl = 4'h6;
        OP_OR: begin
          outctl = 4'h6;
          alt    = 1'b1;
        end
        OP_XOR: outctl = 4'hA;
        OP_NOT: begin
          outctl = 4'hA;
          alt    = 1'b1;
        end
        OP_SHL: outctl = 4'h7;
        OP_RCL: begin
          outctl = 4'h7;
          cin    = carry;
        end
        OP_SWAP: begin
          outctl = 4'h7;
          alt    = 1'b1;
          calcfn = 1'b1;
        end
        OP_MOV: begin
          outctl = {2'b00, src_q};
          calcfn = 1'b1;
        end
        OP_CLR: begin
          outctl = 4'hA;
          arg_r  = {1'b0, dst_q};
        end
        OP_CMP: begin
          outctl  = 4'h5;
          alt     = 1'b1;
          cin     = 1'b1;
          loadctl = 4'hF;
        end
        OP_INC: begin
          outctl = 4'h5;
          arg_r  = 3'd6;
          cin    = 1'b1;
        end
        default: begin
          outctl  = 4'hF;
          loadctl = 4'hF;
          calcfn  = 1'b1;
        end
      endcase
    end
  end

endmodule
